// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO with
// first-word-fall-through output, valid/ready on both sides and a one-cycle flush.
module fetch_queue #(
   parameter int N     = 64,
   parameter int IW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid_F,
   output logic                         in_ready_F,
   input  logic [N-1:0]                 pc_F,
   input  logic [IW-1:0]                instr_F,
   input  logic                         flush_D,
   output logic                         out_valid_D,
   input  logic                         out_ready_D,
   output logic [N-1:0]                 pc_D,
   output logic [IW-1:0]                instr_D,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [N-1:0]  pc_mem    [DEPTH];
   logic [IW-1:0] instr_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] occ;
   logic          enq;
   logic          deq;

   always_comb begin
      in_ready_F  = (occ != CW'(DEPTH));
      out_valid_D = (occ != '0);
      enq         = in_valid_F && in_ready_F && !flush_D;
      deq         = out_valid_D && out_ready_D && !flush_D;
      count       = occ;
      // Outputs are forced to zero when empty so stale storage never leaks out.
      pc_D        = out_valid_D ? pc_mem[rd_ptr]    : '0;
      instr_D     = out_valid_D ? instr_mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[wr_ptr]    <= pc_F;
         instr_mem[wr_ptr] <= instr_F;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else if (flush_D) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         case ({enq, deq})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_queue;

   localparam int N     = 64;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid_F;
   logic          in_ready_F;
   logic [N-1:0]  pc_F;
   logic [IW-1:0] instr_F;
   logic          flush_D;
   logic          out_valid_D;
   logic          out_ready_D;
   logic [N-1:0]  pc_D;
   logic [IW-1:0] instr_D;
   logic [CW-1:0] count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model: each entry is {pc, instr}, head at index 0.
   logic [N+IW-1:0] model_q [$];

   fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid_F  (in_valid_F),
      .in_ready_F  (in_ready_F),
      .pc_F        (pc_F),
      .instr_F     (instr_F),
      .flush_D     (flush_D),
      .out_valid_D (out_valid_D),
      .out_ready_D (out_ready_D),
      .pc_D        (pc_D),
      .instr_D     (instr_D),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0]  epc;
      logic [IW-1:0] ein;
      epc = '0;
      ein = '0;
      if (model_q.size() != 0) begin
         epc = model_q[0][N+IW-1:IW];
         ein = model_q[0][IW-1:0];
      end
      check_eq({tag, ".count"},     96'(count),       96'(model_q.size()));
      check_eq({tag, ".out_valid"}, 96'(out_valid_D), 96'(model_q.size() != 0));
      check_eq({tag, ".in_ready"},  96'(in_ready_F),  96'(model_q.size() != DEPTH));
      check_eq({tag, ".pc"},        96'(pc_D),        96'(epc));
      check_eq({tag, ".instr"},     96'(instr_D),     96'(ein));
   endtask

   // Called just after a negedge: drive inputs, advance one edge, update model, check.
   task automatic cyc(input string tag, input logic iv, input logic [N-1:0] pc,
                      input logic [IW-1:0] ins, input logic fl, input logic ordy);
      logic was_valid, was_ready;
      in_valid_F  = iv;
      pc_F        = pc;
      instr_F     = ins;
      flush_D     = fl;
      out_ready_D = ordy;
      was_valid   = (model_q.size() != 0);
      was_ready   = (model_q.size() != DEPTH);
      @(posedge clk);
      if (fl) model_q.delete();
      else begin
         if (was_valid && ordy) void'(model_q.pop_front());
         if (was_ready && iv) model_q.push_back({pc, ins});
      end
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      reset       = 1'b0;
      in_valid_F  = 1'b0;
      pc_F        = '0;
      instr_F     = '0;
      flush_D     = 1'b0;
      out_ready_D = 1'b0;
      #1;
      check_model("reset_async");
      @(negedge clk);
      check_model("reset");
      reset = 1'b1;

      // Single enqueue appears after one edge.
      cyc("tp1", 1'b1, 64'h0, 32'h8B020020, 1'b0, 1'b0);
      check_eq("tp1.pc_const", 96'(pc_D), 96'(0));
      check_eq("tp1.instr_const", 96'(instr_D), 96'(32'h8B020020));

      // Fill, then offer a fifth entry while full.
      for (int unsigned i = 1; i < 4; i++)
         cyc("tp2_fill", 1'b1, 64'(4*i), 32'h1000 + i, 1'b0, 1'b0);
      check_eq("tp2.in_ready_full", 96'(in_ready_F), 96'(0));
      cyc("tp2_over", 1'b1, 64'h10, 32'hDEAD, 1'b0, 1'b0);
      check_eq("tp2.head_held", 96'(pc_D), 96'(0));

      // Full queue with simultaneous offer and drain: offer must be refused.
      cyc("tp2_full_deq", 1'b1, 64'h10, 32'hBEEF, 1'b0, 1'b1);
      check_eq("tp2.no_enq_full", 96'(count), 96'(3));

      // Drain remaining.
      for (int unsigned i = 0; i < 3; i++)
         cyc("tp3_drain", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
      check_eq("tp3.empty", 96'(out_valid_D), 96'(0));
      cyc("tp3_deq_empty", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

      // Streaming 10 entries through, wrapping pointers.
      for (int unsigned i = 0; i < 10; i++) begin
         cyc("tp4_stream", 1'b1, 64'(4*i), 32'hA000 + i, 1'b0, 1'b1);
         check_eq("tp4.count_one", 96'(count), 96'(1));
      end
      cyc("tp4_tail", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

      // Flush discards queued entries and the same-cycle offer.
      for (int unsigned i = 0; i < 3; i++)
         cyc("tp5_fill", 1'b1, 64'h10 + 64'(4*i), 32'hB000 + i, 1'b0, 1'b0);
      cyc("tp5_flush", 1'b1, 64'h1C, 32'hB003, 1'b1, 1'b1);
      check_eq("tp5.count_zero", 96'(count), 96'(0));
      cyc("tp5_flush2", 1'b1, 64'h20, 32'hB004, 1'b1, 1'b0);
      cyc("tp5_after", 1'b1, 64'h40, 32'hC000, 1'b0, 1'b0);
      check_eq("tp5.new_head", 96'(pc_D), 96'(64'h40));

      // Asynchronous reset mid-cycle with entries held.
      cyc("tp6_fill", 1'b1, 64'h44, 32'hC001, 1'b0, 1'b0);
      cyc("tp6_fill", 1'b1, 64'h48, 32'hC002, 1'b0, 1'b0);
      in_valid_F = 1'b0;
      #2;
      reset = 1'b0;
      model_q.delete();
      #1;
      check_model("tp6_async");
      check_eq("tp6.count_zero", 96'(count), 96'(0));
      @(negedge clk);
      reset = 1'b1;
      check_eq("tp6.in_ready", 96'(in_ready_F), 96'(1));

      // Random traffic.
      for (int unsigned i = 0; i < 800; i++) begin
         cyc("rand",
             ($urandom_range(0, 3) != 0),
             {$urandom, $urandom},
             $urandom,
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the fetch stage. It captures each (PC, instruction word) pair produced by fetch and the instruction memory.
- Presents pairs to decode in order through a valid/ready handshake, decoupling fetch from decode stalls.
- Supports a single-cycle flush when a branch is resolved taken.
- Circular FIFO storage with first-word-fall-through output.

Parameters:
N, 64, PC/address width in bits
IW, 32, instruction word width in bits
DEPTH, 4, number of entries; must be a power of two, >= 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid_F  input  1  fetch offers a pair this cycle
in_ready_F  output  1  queue can accept a pair this cycle
pc_F  input  N  PC of offered instruction
instr_F  input  IW  offered instruction word
flush_D  input  1  discard all queued and incoming entries (taken branch)
out_valid_D  output  1  head entry is valid for decode
out_ready_D  input  1  decode consumes head this cycle
pc_D  output  N  PC of head entry
instr_D  output  IW  instruction of head entry
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - Read/write pointers = 0, count = 0.
  - out_valid_D = 0; pc_D = 0; instr_D = 0; in_ready_F = 1.
  - Storage contents are don't-care.
  - Reset mid-operation drops every entry immediately, with no waiting for a clock edge.
- Enqueue: occurs on the clk edge where in_valid_F=1, in_ready_F=1 and flush_D=0.
  - Writes {pc_F, instr_F} at the write pointer.
  - Write pointer advances by 1 modulo DEPTH.
- Dequeue: occurs on the clk edge where out_valid_D=1, out_ready_D=1 and flush_D=0.
  - Read pointer advances by 1 modulo DEPTH.
- in_ready_F = (count != DEPTH).
  - Combinational from state only, with no dependence on out_ready_D.
  - No enqueue while full, even if a dequeue happens the same cycle.
- out_valid_D = (count != 0). pc_D and instr_D show the head entry when valid, 0 when empty.
- Latency: a pair enqueued at edge k is visible at the outputs after edge k (out_valid_D=1 in cycle k+1). There is no same-cycle bypass from input to output.
- Count update per edge:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue (possible when 0 < count < DEPTH).
  - count never exceeds DEPTH and never underflows.
- Flush (synchronous, highest priority among non-reset events):
  - On an edge with flush_D=1, pointers and count go to 0.
  - Any enqueue or dequeue attempted that cycle is discarded.
  - out_valid_D=0 and in_ready_F=1 from the next cycle.
  - Back-to-back flushes keep the queue empty.
- Wrap-around: pointers wrap from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- Head stability: while out_valid_D=1 and out_ready_D=0, pc_D/instr_D are held constant. Enqueues do not disturb the head.
- Write to a full queue (in_valid_F=1, in_ready_F=0): ignored, with no state change. Fetch must hold its PC; that is not this block's concern.
- Dequeue from an empty queue (out_ready_D=1, out_valid_D=0): ignored.

Test Plan:
- Reset release, then in_valid_F=1 with pc_F=0x0, instr_F=0x8B020020, out_ready_D=0 -> next cycle out_valid_D=1, pc_D=0x0, instr_D=0x8B020020, count=1.
- Enqueue PCs 0x0,0x4,0x8,0xC with out_ready_D=0 -> count=4 and in_ready_F=0. A fifth offer of PC 0x10 is ignored. Head stays 0x0.
- From full, hold out_ready_D=1 for 4 cycles -> pc_D sequence 0x0,0x4,0x8,0xC, then out_valid_D=0, count=0.
- Continuous streaming of 10 entries (PC 0x0..0x24) with in_valid_F=1 and out_ready_D=1 -> count stays 1, decode receives all 10 in order, and pointer wrap-around is exercised.
- Queue holding PCs 0x10,0x14,0x18; flush_D=1 for one cycle while in_valid_F=1 with PC 0x1C -> next cycle count=0 and out_valid_D=0. PC 0x1C is never output. The next enqueue of PC 0x40 appears as the head.
- Queue holding 3 entries; drive reset=0 asynchronously mid-cycle -> out_valid_D, pc_D, instr_D and count go to 0 before the next clk edge. After release, in_ready_F=1.
